// File: rtl/sim_status_pkg.sv
// Shared definitions for the simulation status port: register offsets,
// FSM state encoding and STATUS register bit positions.
package sim_status_pkg;

  // Word offsets inside the 16-byte register window (mem_addr[3:2])
  localparam logic [1:0] OFS_TOHOST  = 2'd0;
  localparam logic [1:0] OFS_CONSOLE = 2'd1;
  localparam logic [1:0] OFS_CYCLE   = 2'd2;
  localparam logic [1:0] OFS_STATUS  = 2'd3;

  // Run state: RUN until the program finishes or the watchdog fires
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // STATUS register bit positions
  localparam int STATUS_DONE_BIT    = 0;
  localparam int STATUS_PASS_BIT    = 1;
  localparam int STATUS_TIMEOUT_BIT = 2;

  // Pack the sticky result flags into the STATUS read word
  function automatic logic [31:0] status_word(input logic done,
                                              input logic pass,
                                              input logic timeout);
    logic [31:0] w;
    w = '0;
    w[STATUS_DONE_BIT]    = done;
    w[STATUS_PASS_BIT]    = pass;
    w[STATUS_TIMEOUT_BIT] = timeout;
    return w;
  endfunction

endpackage

// File: rtl/sim_watchdog_counter.sv
// Free-running 32-bit cycle counter with a freeze enable and a terminal-count
// flag that marks the last cycle before the watchdog limit. A limit of 0
// disables the terminal count entirely.
module sim_watchdog_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] cnt,
  output logic        tc
);

  localparam logic [31:0] TC_VAL = 32'(TIMEOUT_CYCLES - 32'd1);

  // Count while enabled; wraps silently at 2^32-1
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 32'd1;
    end
  end

  assign tc = (TIMEOUT_CYCLES != 32'd0) && (cnt == TC_VAL);

endmodule

// File: rtl/sim_status_port.sv
// Memory-mapped simulation status responder. The program under test writes
// TOHOST to finish (pass/fail with exit code) and CONSOLE to emit bytes; the
// bench watches done/pass/timeout. A watchdog ends hung runs.
// Optional feature: define SIM_STATUS_INSTRET_EN to add an instret_inc input
// and a retired-instruction counter readable at the TOHOST offset.
module sim_status_port
  import sim_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0F00,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
`ifdef SIM_STATUS_INSTRET_EN
  input  logic        instret_inc,
`endif
  output logic [31:0] mem_rdata,
  output logic        sel,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] exit_code,
  output logic        char_valid,
  output logic [7:0]  char_data
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ofs;
  logic        wr_hit;
  logic        tohost_fin;
  logic        console_wr;
  logic        cnt_en;
  logic        wdog_tc;
  logic [31:0] cycle_cnt;
  logic [31:0] tohost_rd;
  logic        unused_addr_bits;

  // Byte lanes inside a word are not decoded
  assign unused_addr_bits = ^mem_addr[1:0];

  assign sel    = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign ofs    = mem_addr[3:2];
  assign wr_hit = sel && mem_we;

  // Writes only take effect while the program is still running
  assign tohost_fin = wr_hit && (ofs == OFS_TOHOST) && (state == ST_RUN) && mem_wdata[0];
  assign console_wr = wr_hit && (ofs == OFS_CONSOLE) && (state == ST_RUN);

  // The counter advances only on edges that leave the block in RUN, so it
  // freezes at the value seen in the finishing cycle
  assign cnt_en = (state == ST_RUN) && (state_nxt == ST_RUN);

  sim_watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .cnt (cycle_cnt),
    .tc  (wdog_tc)
  );

  // Next-state: a finishing TOHOST write takes priority over the watchdog
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (tohost_fin) begin
          state_nxt = (mem_wdata[31:1] == 31'd0) ? ST_PASS : ST_FAIL;
        end else if (wdog_tc) begin
          state_nxt = ST_TIMEOUT;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // State register; DONE states hold until reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered result flags and exit code, updated on the finishing edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      exit_code <= '0;
    end else begin
      done    <= (state_nxt != ST_RUN);
      pass    <= (state_nxt == ST_PASS);
      timeout <= (state_nxt == ST_TIMEOUT);
      if (tohost_fin) begin
        exit_code <= mem_wdata[31:1];
      end
    end
  end

  // Console byte latch and single-cycle strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      char_valid <= 1'b0;
      char_data  <= '0;
    end else begin
      char_valid <= console_wr;
      if (console_wr) begin
        char_data <= mem_wdata[7:0];
      end
    end
  end

`ifdef SIM_STATUS_INSTRET_EN
  logic [31:0] instret_cnt;

  // Retired-instruction count, frozen once the run has finished
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_cnt <= '0;
    end else if ((state == ST_RUN) && instret_inc) begin
      instret_cnt <= instret_cnt + 32'd1;
    end
  end

  assign tohost_rd = instret_cnt;
`else
  assign tohost_rd = '0;
`endif

  // Combinational read decode; unselected addresses read as zero
  always_comb begin
    mem_rdata = '0;
    if (sel) begin
      case (ofs)
        OFS_TOHOST:  mem_rdata = tohost_rd;
        OFS_CONSOLE: mem_rdata = '0;
        OFS_CYCLE:   mem_rdata = cycle_cnt;
        OFS_STATUS:  mem_rdata = status_word(done, pass, timeout);
        default:     mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_status_port.sv
// Bench for sim_status_port: a directed vector table, hand-written timeout
// sequences, and randomized traffic checked against a behavioural model.
module tb_sim_status_port;

  localparam logic [31:0] B  = 32'h0000_0F00;
  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        instret_inc;
  logic [31:0] mem_rdata;
  logic        sel;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [30:0] exit_code;
  logic        char_valid;
  logic [7:0]  char_data;

  sim_status_port #(
    .BASE_ADDR(B),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
`ifdef SIM_STATUS_INSTRET_EN
    .instret_inc(instret_inc),
`endif
    .mem_rdata  (mem_rdata),
    .sel        (sel),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .exit_code  (exit_code),
    .char_valid (char_valid),
    .char_data  (char_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic        m_done, m_pass, m_to, m_cv;
  logic [30:0] m_exit;
  logic [7:0]  m_cd;
  logic [31:0] m_cyc, m_instret;
  logic [31:0] m_rd_exp;
  logic        m_sel_exp;

  // Mid-cycle samples of the combinational outputs
  logic [31:0] s_rdata;
  logic        s_sel;

  typedef struct {
    logic        r;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        sl;
    logic [31:0] rd;
    logic        dn;
    logic        ps;
    logic        to;
    logic [30:0] ex;
    logic        cv;
    logic [7:0]  cd;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string tag, input logic dn, input logic ps, input logic to,
                          input logic [30:0] ex, input logic cv, input logic [7:0] cd);
    chk({tag, ".done"},       32'(done),       32'(dn));
    chk({tag, ".pass"},       32'(pass),       32'(ps));
    chk({tag, ".timeout"},    32'(timeout),    32'(to));
    chk({tag, ".exit_code"},  32'(exit_code),  32'(ex));
    chk({tag, ".char_valid"}, 32'(char_valid), 32'(cv));
    chk({tag, ".char_data"},  32'(char_data),  32'(cd));
  endtask

  // Expected read value straight from the register map
  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != B[31:4]) return 32'd0;
    case (a[3:2])
`ifdef SIM_STATUS_INSTRET_EN
      2'd0: return m_instret;
`endif
      2'd2: return m_cyc;
      2'd3: return {29'd0, m_to, m_pass, m_done};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the model
  task automatic model_step(input logic r, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic inc);
    logic hit;
    logic [1:0] o;
    if (!r) begin
      m_done = 0; m_pass = 0; m_to = 0; m_cv = 0;
      m_exit = '0; m_cd = '0; m_cyc = '0; m_instret = '0;
    end else if (!m_done) begin
      hit  = we && (a[31:4] == B[31:4]);
      o    = a[3:2];
      m_cv = hit && (o == 2'd1);
      if (m_cv) m_cd = d[7:0];
      if (inc) m_instret = m_instret + 1;
      if (hit && (o == 2'd0) && d[0]) begin
        m_done = 1;
        m_pass = (d[31:1] == 31'd0);
        m_exit = d[31:1];
      end else if (m_cyc == TO - 1) begin
        m_done = 1;
        m_to   = 1;
      end else begin
        m_cyc = m_cyc + 1;
      end
    end else begin
      m_cv = 0;
    end
  endtask

  // Drive one cycle: sample combinational outputs mid-cycle, then step past the edge
  task automatic cycle(input logic r, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic inc);
    rst = r; mem_we = we; mem_addr = a; mem_wdata = d; instret_inc = inc;
    m_rd_exp  = model_read(a);
    m_sel_exp = (a[31:4] == B[31:4]);
    #4;
    s_rdata = mem_rdata;
    s_sel   = sel;
    @(posedge clk);
    model_step(r, we, a, d, inc);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic        r, we, inc;
    logic [31:0] a, d;

    m_done = 0; m_pass = 0; m_to = 0; m_cv = 0;
    m_exit = '0; m_cd = '0; m_cyc = '0; m_instret = '0;

    //            r  we  addr       wdata          sel rd     dn ps to ex      cv cd
    tbl[0]  = '{1, 0, B + 32'h8,  32'h0,        1, 32'd10, 0, 0, 0, 31'd0,  0, 8'h00};
    tbl[1]  = '{1, 0, B + 32'hC,  32'h0,        1, 32'd0,  0, 0, 0, 31'd0,  0, 8'h00};
    tbl[2]  = '{1, 1, B + 32'h4,  32'h41,       1, 32'd0,  0, 0, 0, 31'd0,  1, 8'h41};
    tbl[3]  = '{1, 1, B + 32'h5,  32'h142,      1, 32'd0,  0, 0, 0, 31'd0,  1, 8'h42};
    tbl[4]  = '{1, 1, B + 32'h10, 32'h1,        0, 32'd0,  0, 0, 0, 31'd0,  0, 8'h42};
    tbl[5]  = '{1, 0, B + 32'h8,  32'h0,        1, 32'd15, 0, 0, 0, 31'd0,  0, 8'h42};
    tbl[6]  = '{1, 1, B,          32'h0,        1, 32'd0,  0, 0, 0, 31'd0,  0, 8'h42};
    tbl[7]  = '{1, 1, B,          32'h1,        1, 32'd0,  1, 1, 0, 31'd0,  0, 8'h42};
    tbl[8]  = '{1, 0, B + 32'hC,  32'h0,        1, 32'd3,  1, 1, 0, 31'd0,  0, 8'h42};
    tbl[9]  = '{1, 1, B,          32'h7,        1, 32'd0,  1, 1, 0, 31'd0,  0, 8'h42};
    tbl[10] = '{1, 0, B + 32'h8,  32'h0,        1, 32'd17, 1, 1, 0, 31'd0,  0, 8'h42};
    tbl[11] = '{0, 0, B + 32'hC,  32'h0,        1, 32'd3,  0, 0, 0, 31'd0,  0, 8'h00};
    tbl[12] = '{1, 1, B,          32'h55,       1, 32'd0,  1, 0, 0, 31'd42, 0, 8'h00};
    tbl[13] = '{1, 1, B + 32'h4,  32'h99,       1, 32'd0,  1, 0, 0, 31'd42, 0, 8'h00};
    tbl[14] = '{1, 0, B + 32'hC,  32'h0,        1, 32'd1,  1, 0, 0, 31'd42, 0, 8'h00};
    tbl[15] = '{0, 0, B + 32'h8,  32'h0,        1, 32'd0,  0, 0, 0, 31'd0,  0, 8'h00};
    tbl[16] = '{1, 0, B + 32'h8,  32'h0,        1, 32'd0,  0, 0, 0, 31'd0,  0, 8'h00};
    tbl[17] = '{1, 0, B + 32'h8,  32'h0,        1, 32'd1,  0, 0, 0, 31'd0,  0, 8'h00};

    // Reset for two cycles, then ten idle cycles
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk_regs("reset", 0, 0, 0, 31'd0, 0, 8'h00);
    idle(10);
    chk_regs("idle10", 0, 0, 0, 31'd0, 0, 8'h00);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].d, 1'b0);
      chk($sformatf("vec%0d.sel", i), 32'(s_sel), 32'(tbl[i].sl));
      chk($sformatf("vec%0d.rdata", i), s_rdata, tbl[i].rd);
      chk_regs($sformatf("vec%0d", i), tbl[i].dn, tbl[i].ps, tbl[i].to,
               tbl[i].ex, tbl[i].cv, tbl[i].cd);
    end

    // Watchdog expiry with no writes: fires on the 20th edge, counter holds 19
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(TO - 1);
    chk_regs("to_pre", 0, 0, 0, 31'd0, 0, 8'h00);
    cycle(1'b1, 1'b0, B + 32'h8, 32'h0, 1'b0);
    chk("to_last.cycle", s_rdata, 32'd19);
    chk_regs("to_fire", 1, 0, 1, 31'd0, 0, 8'h00);
    idle(3);
    cycle(1'b1, 1'b0, B + 32'h8, 32'h0, 1'b0);
    chk("to_frozen.cycle", s_rdata, 32'd19);
    cycle(1'b1, 1'b0, B + 32'hC, 32'h0, 1'b0);
    chk("to.status", s_rdata, 32'd5);

    // Finishing write in the watchdog's last cycle wins
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(TO - 1);
    cycle(1'b1, 1'b1, B, 32'h1, 1'b0);
    chk_regs("race", 1, 1, 0, 31'd0, 0, 8'h00);
    cycle(1'b1, 1'b0, B + 32'h8, 32'h0, 1'b0);
    chk("race.cycle", s_rdata, 32'd19);

    // Randomized traffic against the model
    for (int run = 0; run < 40; run++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int k = 0; k < 30; k++) begin
        r   = ($urandom_range(0, 24) != 0);
        we  = 1'($urandom_range(0, 1));
        inc = 1'($urandom_range(0, 1));
        a   = ($urandom_range(0, 3) != 0) ? (B | 32'($urandom_range(0, 15))) : $urandom;
        case ($urandom_range(0, 7))
          0:       d = 32'h1;
          1:       d = 32'h55;
          2:       d = $urandom;
          default: d = $urandom & 32'hFFFF_FFFE;
        endcase
        cycle(r, we, a, d, inc);
        chk("rnd.sel", 32'(s_sel), 32'(m_sel_exp));
        chk("rnd.rdata", s_rdata, m_rd_exp);
        chk_regs("rnd", m_done, m_pass, m_to, m_exit, m_cv, m_cd);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
